// File: rtl/decode_stage.sv
// RV32I decode stage: combinational field/immediate decode captured into an
// output register, with an optional skid entry so in_ready is registered.
package decode_pkg;
  typedef enum logic [3:0] {
    ALU_NONE = 4'b0000,
    ALU_ADD  = 4'b0001,
    ALU_SUB  = 4'b0010,
    ALU_AND  = 4'b0011,
    ALU_OR   = 4'b0100,
    ALU_ADDI = 4'b0101
  } alu_op_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
endpackage

module decode_stage #(
  parameter int XLEN    = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic [3:0]      alu_op,
  output logic            we,
  output logic            writeback,
  output logic            is_jump,
  output logic            is_branch,
  output logic            is_load,
  output logic            is_store,
  output logic            illegal
);
  import decode_pkg::*;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu_op;
    logic            we;
    logic            writeback;
    logic            is_jump;
    logic            is_branch;
    logic            is_load;
    logic            is_store;
    logic            illegal;
  } dec_t;

  dec_t        dec;
  logic [31:0] imm32;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    dec        = '0;
    imm32      = '0;
    dec.pc     = in_pc;
    dec.opcode = in_inst[6:0];
    dec.funct3 = in_inst[14:12];
    dec.funct7 = in_inst[31:25];
    dec.rs1    = in_inst[19:15];
    dec.rs2    = in_inst[24:20];
    dec.rd     = in_inst[11:7];
    case (in_inst[6:0])
      OP_R: begin
        dec.we = 1'b1;
        case (in_inst[14:12])
          3'b000:  dec.alu_op = (in_inst[31:25] == 7'b0100000) ? ALU_SUB : ALU_ADD;
          3'b111:  dec.alu_op = ALU_AND;
          3'b110:  dec.alu_op = ALU_OR;
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_I: begin
        dec.we = 1'b1;
        imm32  = {{20{in_inst[31]}}, in_inst[31:20]};
        if (in_inst[14:12] == 3'b000) dec.alu_op = ALU_ADDI;
        else                          dec.illegal = 1'b1;
      end
      OP_LOAD: begin
        dec.we        = 1'b1;
        dec.writeback = 1'b1;
        dec.is_load   = 1'b1;
        dec.alu_op    = ALU_ADD;
        imm32         = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      OP_STORE: begin
        dec.is_store = 1'b1;
        dec.alu_op   = ALU_ADD;
        imm32        = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      end
      OP_BRANCH: begin
        dec.is_branch = 1'b1;
        imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
      end
      OP_LUI: begin
        // LUI executes as ADDI on x0, so the rs1 field is forced to zero.
        dec.we        = 1'b1;
        dec.writeback = 1'b1;
        dec.alu_op    = ALU_ADDI;
        dec.rs1       = '0;
        imm32         = {in_inst[31:12], 12'b0};
      end
      OP_JAL: begin
        dec.we        = 1'b1;
        dec.writeback = 1'b1;
        dec.is_jump   = 1'b1;
        imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
      end
      OP_JALR: begin
        dec.we        = 1'b1;
        dec.writeback = 1'b1;
        dec.is_jump   = 1'b1;
        imm32         = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.illegal) begin
      dec.we     = 1'b0;
      dec.alu_op = ALU_NONE;
    end
    dec.imm = XLEN'($signed(imm32));
  end

  dec_t main_q, skid_q;
  logic main_valid, skid_valid;
  logic accept, main_free;

  // Without the skid entry the ready path is combinational from out_ready.
  assign in_ready  = SKID_EN ? !skid_valid : (!main_valid || out_ready);
  assign accept    = in_valid && in_ready && !flush;
  assign main_free = !main_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= accept;
        if (accept) main_q <= dec;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
    end
  end

  // NOTE: skid payload has no reset; skid_valid alone decides whether it is meaningful.
  always_ff @(posedge clk) begin
    if (!flush && !main_free && accept) skid_q <= dec;
  end

  assign out_valid = main_valid;
  assign out_pc    = main_q.pc;
  assign opcode    = main_q.opcode;
  assign funct3    = main_q.funct3;
  assign funct7    = main_q.funct7;
  assign rs1       = main_q.rs1;
  assign rs2       = main_q.rs2;
  assign rd        = main_q.rd;
  assign imm       = main_q.imm;
  assign alu_op    = main_q.alu_op;
  assign we        = main_q.we;
  assign writeback = main_q.writeback;
  assign is_jump   = main_q.is_jump;
  assign is_branch = main_q.is_branch;
  assign is_load   = main_q.is_load;
  assign is_store  = main_q.is_store;
  assign illegal   = main_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: a 32-bit skid instance and a 64-bit no-skid instance
// share stimulus; each has its own expected-queue scoreboard fed by a reference decoder.
module tb_decode_stage;
  import decode_pkg::*;

  typedef struct packed {
    logic [63:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] imm;
    logic [3:0]  alu_op;
    logic        we;
    logic        writeback;
    logic        is_jump;
    logic        is_branch;
    logic        is_load;
    logic        is_store;
    logic        illegal;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_inst = '0;
  logic [31:0] in_pc = '0;

  logic        in_ready_a, out_valid_a, we_a, wb_a, jump_a, branch_a, load_a, store_a, ill_a;
  logic [31:0] out_pc_a, imm_a;
  logic [6:0]  opcode_a, funct7_a;
  logic [2:0]  funct3_a;
  logic [4:0]  rs1_a, rs2_a, rd_a;
  logic [3:0]  alu_op_a;

  logic        in_ready_b, out_valid_b, we_b, wb_b, jump_b, branch_b, load_b, store_b, ill_b;
  logic [63:0] out_pc_b, imm_b;
  logic [6:0]  opcode_b, funct7_b;
  logic [2:0]  funct3_b;
  logic [4:0]  rs1_b, rs2_b, rd_b;
  logic [3:0]  alu_op_b;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .SKID_EN(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_pc(out_pc_a),
    .opcode(opcode_a), .funct3(funct3_a), .funct7(funct7_a),
    .rs1(rs1_a), .rs2(rs2_a), .rd(rd_a), .imm(imm_a), .alu_op(alu_op_a),
    .we(we_a), .writeback(wb_a), .is_jump(jump_a), .is_branch(branch_a),
    .is_load(load_a), .is_store(store_a), .illegal(ill_a)
  );

  decode_stage #(.XLEN(64), .SKID_EN(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_inst(in_inst), .in_pc({32'b0, in_pc}),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_pc(out_pc_b),
    .opcode(opcode_b), .funct3(funct3_b), .funct7(funct7_b),
    .rs1(rs1_b), .rs2(rs2_b), .rd(rd_b), .imm(imm_b), .alu_op(alu_op_b),
    .we(we_b), .writeback(wb_b), .is_jump(jump_b), .is_branch(branch_b),
    .is_load(load_b), .is_store(store_b), .illegal(ill_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic check_dec(input string name, input exp_t act, input exp_t req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Reference decoder: immediates are computed as signed integers from bit weights.
  function automatic exp_t ref_decode(input logic [31:0] inst, input logic [63:0] pc);
    exp_t   e;
    longint v;
    e = '0;
    v = 0;
    e.pc = pc;
    e.opcode = inst[6:0];
    e.funct3 = inst[14:12];
    e.funct7 = inst[31:25];
    e.rs1 = inst[19:15];
    e.rs2 = inst[24:20];
    e.rd = inst[11:7];
    case (inst[6:0])
      7'h33: begin
        e.we = 1'b1;
        if (inst[14:12] == 3'd0)      e.alu_op = (inst[31:25] == 7'h20) ? ALU_SUB : ALU_ADD;
        else if (inst[14:12] == 3'd7) e.alu_op = ALU_AND;
        else if (inst[14:12] == 3'd6) e.alu_op = ALU_OR;
        else                          e.illegal = 1'b1;
      end
      7'h13: begin
        e.we = 1'b1;
        v = longint'(inst[30:20]) - (inst[31] ? 64'sd2048 : 64'sd0);
        if (inst[14:12] == 3'd0) e.alu_op = ALU_ADDI;
        else                     e.illegal = 1'b1;
      end
      7'h03: begin
        e.we = 1'b1; e.writeback = 1'b1; e.is_load = 1'b1; e.alu_op = ALU_ADD;
        v = longint'(inst[30:20]) - (inst[31] ? 64'sd2048 : 64'sd0);
      end
      7'h23: begin
        e.is_store = 1'b1; e.alu_op = ALU_ADD;
        v = longint'(inst[30:25]) * 64'sd32 + longint'(inst[11:7]) - (inst[31] ? 64'sd2048 : 64'sd0);
      end
      7'h63: begin
        e.is_branch = 1'b1;
        v = longint'(inst[7]) * 64'sd2048 + longint'(inst[30:25]) * 64'sd32
          + longint'(inst[11:8]) * 64'sd2 - (inst[31] ? 64'sd4096 : 64'sd0);
      end
      7'h37: begin
        e.we = 1'b1; e.writeback = 1'b1; e.alu_op = ALU_ADDI; e.rs1 = 5'd0;
        v = longint'($signed(inst[31:12])) * 64'sd4096;
      end
      7'h6F: begin
        e.we = 1'b1; e.writeback = 1'b1; e.is_jump = 1'b1;
        v = longint'(inst[19:12]) * 64'sd4096 + longint'(inst[20]) * 64'sd2048
          + longint'(inst[30:21]) * 64'sd2 - (inst[31] ? 64'sd1048576 : 64'sd0);
      end
      7'h67: begin
        e.we = 1'b1; e.writeback = 1'b1; e.is_jump = 1'b1;
        v = longint'(inst[30:20]) - (inst[31] ? 64'sd2048 : 64'sd0);
      end
      default: e.illegal = 1'b1;
    endcase
    if (e.illegal) begin
      e.we = 1'b0;
      e.alu_op = ALU_NONE;
    end
    e.imm = 64'(v);
    return e;
  endfunction

  function automatic exp_t narrow(input exp_t e);
    exp_t n;
    n = e;
    n.pc  = {32'b0, e.pc[31:0]};
    n.imm = {32'b0, e.imm[31:0]};
    return n;
  endfunction

  function automatic exp_t pack_a();
    return '{pc: 64'(out_pc_a), opcode: opcode_a, funct3: funct3_a, funct7: funct7_a,
             rs1: rs1_a, rs2: rs2_a, rd: rd_a, imm: 64'(imm_a), alu_op: alu_op_a,
             we: we_a, writeback: wb_a, is_jump: jump_a, is_branch: branch_a,
             is_load: load_a, is_store: store_a, illegal: ill_a};
  endfunction

  function automatic exp_t pack_b();
    return '{pc: out_pc_b, opcode: opcode_b, funct3: funct3_b, funct7: funct7_b,
             rs1: rs1_b, rs2: rs2_b, rd: rd_b, imm: imm_b, alu_op: alu_op_b,
             we: we_b, writeback: wb_b, is_jump: jump_b, is_branch: branch_b,
             is_load: load_b, is_store: store_b, illegal: ill_b};
  endfunction

  logic [6:0] op_tab [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h6F, 7'h67, 7'h17, 7'h7F};

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom();
    r[6:0] = op_tab[$urandom_range(9)];
    if ($urandom_range(3) == 0) r[31:25] = ($urandom_range(1) == 1) ? 7'h20 : 7'h00;
    return r;
  endfunction

  // Scoreboard monitor: samples handshakes on the falling edge, ahead of the edge that takes them.
  exp_t qa[$];
  exp_t qb[$];
  exp_t prev_a;
  logic hold_a = 1'b0;
  int   n_out_a = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      qa.delete();
      qb.delete();
      hold_a = 1'b0;
    end else begin
      if (hold_a) begin
        check("hold_valid_a", 64'(out_valid_a), 64'd1);
        check_dec("hold_fields_a", pack_a(), prev_a);
      end
      if (out_valid_a && out_ready) begin
        n_out_a++;
        if (qa.size() == 0) begin
          total++; bad++;
          $display("FAIL out_a: unexpected output pc=%h with nothing pending", out_pc_a);
        end else check_dec("out_a", pack_a(), narrow(qa.pop_front()));
      end
      if (out_valid_b && out_ready) begin
        if (qb.size() == 0) begin
          total++; bad++;
          $display("FAIL out_b: unexpected output pc=%h with nothing pending", out_pc_b);
        end else check_dec("out_b", pack_b(), qb.pop_front());
      end
      if (flush) begin
        qa.delete();
        qb.delete();
      end else begin
        if (in_valid && in_ready_a) qa.push_back(ref_decode(in_inst, {32'b0, in_pc}));
        if (in_valid && in_ready_b) qb.push_back(ref_decode(in_inst, {32'b0, in_pc}));
      end
      hold_a = out_valid_a && !out_ready && !flush;
      prev_a = pack_a();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
  endtask

  int n0;

  initial begin
    #12;
    check("rst_out_valid_a", 64'(out_valid_a), 64'd0);
    check("rst_in_ready_a", 64'(in_ready_a), 64'd1);
    check("rst_pc_a", 64'(out_pc_a), 64'd0);
    check("rst_fields_a", 64'({imm_a, alu_op_a, we_a, ill_a, rd_a}), 64'd0);
    check("rst_out_valid_b", 64'(out_valid_b), 64'd0);
    check("rst_in_ready_b", 64'(in_ready_b), 64'd1);
    check("rst_imm_b", imm_b, 64'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();

    offer(32'hFFF00093, 32'h100);
    step();
    in_valid = 1'b0;
    check("addi_valid", 64'(out_valid_a), 64'd1);
    check("addi_imm", 64'(imm_a), 64'hFFFF_FFFF);
    check("addi_alu", 64'(alu_op_a), 64'(ALU_ADDI));
    check("addi_rd", 64'(rd_a), 64'd1);
    check("addi_we_ill", 64'({we_a, ill_a}), 64'b10);
    check("addi_imm_b", imm_b, 64'hFFFF_FFFF_FFFF_FFFF);
    step();

    offer(32'hFE000EE3, 32'h200);
    step();
    check("beq_imm", 64'(imm_a), 64'hFFFF_FFFC);
    check("beq_branch_we", 64'({branch_a, we_a}), 64'b10);
    offer(32'h0000006F, 32'h204);
    step();
    check("jal_imm", 64'(imm_a), 64'd0);
    check("jal_flags", 64'({jump_a, we_a, wb_a}), 64'b111);
    check("jal_pc", 64'(out_pc_a), 64'h204);

    offer(32'h0000007F, 32'h208);
    step();
    check("ill_op", 64'({out_valid_a, ill_a, we_a, alu_op_a}), 64'b110_0000);
    offer(32'h002091B3, 32'h20C);
    step();
    check("ill_r", 64'({out_valid_a, ill_a, we_a, alu_op_a}), 64'b110_0000);
    offer(32'h800000B7, 32'h210);
    step();
    in_valid = 1'b0;
    check("lui64_imm", imm_b, 64'hFFFF_FFFF_8000_0000);
    check("lui64_rs1", 64'(rs1_b), 64'd0);
    check("lui64_alu", 64'(alu_op_b), 64'(ALU_ADDI));
    step();

    n0 = n_out_a;
    offer(32'h00100093, 32'h300);
    step();
    out_ready = 1'b0;
    offer(32'h00200113, 32'h304);
    check("skid_ready_before", 64'(in_ready_a), 64'd1);
    step();
    check("skid_ready_drop", 64'(in_ready_a), 64'd0);
    check("skid_main_pc", 64'(out_pc_a), 64'h300);
    check("noskid_ready_stall", 64'(in_ready_b), 64'd0);
    offer(32'h00300193, 32'h308);
    step();
    step();
    out_ready = 1'b1;
    step();
    check("skid_to_main_pc", 64'(out_pc_a), 64'h304);
    check("skid_ready_back", 64'(in_ready_a), 64'd1);
    step();
    offer(32'h00400213, 32'h30C);
    step();
    in_valid = 1'b0;
    repeat (3) step();
    check("stream_count", 64'(n_out_a - n0), 64'd4);

    out_ready = 1'b0;
    offer(32'h00500293, 32'h400);
    step();
    offer(32'h00600313, 32'h404);
    step();
    check("full_ready", 64'(in_ready_a), 64'd0);
    flush = 1'b1;
    offer(32'h00700393, 32'h408);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_valid_a", 64'(out_valid_a), 64'd0);
    check("flush_ready_a", 64'(in_ready_a), 64'd1);
    check("flush_valid_b", 64'(out_valid_b), 64'd0);
    out_ready = 1'b1;
    repeat (3) step();
    check("flush_stays_empty", 64'(out_valid_a), 64'd0);

    out_ready = 1'b0;
    offer(32'h00800413, 32'h500);
    step();
    offer(32'h00900493, 32'h504);
    step();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid_a", 64'(out_valid_a), 64'd0);
    check("async_rst_valid_b", 64'(out_valid_b), 64'd0);
    check("async_rst_ready_a", 64'(in_ready_a), 64'd1);
    check("async_rst_pc_a", 64'(out_pc_a), 64'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    step();

    in_pc = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(9) < 7);
      in_inst   = rand_inst();
      in_pc     = in_pc + 32'd4;
      flush     = ($urandom_range(29) == 0);
      out_ready = flush ? 1'b0 : ($urandom_range(9) < 6);
      step();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) step();
    check("drain_a", 64'(qa.size()), 64'd0);
    check("drain_b", 64'(qb.size()), 64'd0);
    check("drain_valid_a", 64'(out_valid_a), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
